// File: rtl/banked_unified_buffer.sv
// Banked multi-port buffer between host DMA and the systolic array, with per-bank write
// priority, saturating collision count and a stallable read pipeline. Build option: UB_WRITE_FORWARD_EN.

module banked_unified_buffer_bank #(
  parameter int DW = 8,
  parameter int BD = 16,
  parameter int NW = 2,
  parameter int NR = 2,
  parameter int RL = 1,
  parameter int RB = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   syncRst,
  input  logic                   en,
  input  logic [NW-1:0]          wrValid,
  input  logic [NW-1:0][RB-1:0]  wrAddr,
  input  logic [NW-1:0][DW-1:0]  wrData,
  input  logic [NR-1:0]          rdValid,
  input  logic [NR-1:0][RB-1:0]  rdAddr,
  output logic [NR-1:0][DW-1:0]  rdData,
  output logic [NR-1:0]          rdDataValid,
  output logic [2:0]             dropCnt
);
  logic [BD-1:0][DW-1:0] mem;
  logic [NR-1:0][DW-1:0] rdWord;
  logic                  dup;

  // Descending port order: the lowest-index writer's NBA lands last and wins.
  always_ff @(posedge clk or negedge rstN)
    if (!rstN)        mem <= '0;
    else if (syncRst) mem <= '0;
    else if (en)
      for (int p = NW-1; p >= 0; p--)
        if (wrValid[p]) mem[wrAddr[p]] <= wrData[p];

  always_comb begin
    dropCnt = '0;
    dup     = 1'b0;
    for (int p = 1; p < NW; p++) begin
      dup = 1'b0;
      for (int q = 0; q < p; q++)
        if (wrValid[q] && wrAddr[q] == wrAddr[p]) dup = 1'b1;
      if (wrValid[p] && dup) dropCnt = dropCnt + 3'd1;
    end
  end

  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rdWord[p] = mem[rdAddr[p]];
`ifdef UB_WRITE_FORWARD_EN
      for (int q = NW-1; q >= 0; q--)
        if (wrValid[q] && wrAddr[q] == rdAddr[p]) rdWord[p] = wrData[q];
`endif
    end
  end

  // Stage RL is the output register; it only reloads on a valid so RdData holds.
  for (genvar s = 1; s <= RL; s++) begin : gStage
    logic [NR-1:0]         v, srcV;
    logic [NR-1:0][DW-1:0] d, srcD;
    if (s == 1) begin : gHead
      assign srcV = rdValid;
      assign srcD = rdWord;
    end else begin : gBody
      assign srcV = gStage[s-1].v;
      assign srcD = gStage[s-1].d;
    end
    always_ff @(posedge clk or negedge rstN)
      if (!rstN) begin
        v <= '0;
        d <= '0;
      end else if (syncRst) begin
        v <= '0;
        d <= '0;
      end else if (en) begin
        v <= srcV;
        for (int p = 0; p < NR; p++)
          if (s < RL || srcV[p]) d[p] <= srcD[p];
      end
  end

  assign rdData      = gStage[RL].d;
  assign rdDataValid = gStage[RL].v;
endmodule

module banked_unified_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_BANKS    = 16,
  parameter int BANK_DEPTH   = 16,
  parameter int NUM_WPORTS   = 2,
  parameter int NUM_RPORTS   = 2,
  parameter int READ_LATENCY = 1,
  localparam int ROW_BITS    = $clog2(BANK_DEPTH)
) (
  input  logic                                        CLK,
  input  logic                                        ASYNC_RST,
  input  logic                                        SYNC_RST,
  input  logic                                        EN,
  input  logic [NUM_BANKS*NUM_WPORTS-1:0]             WrValid,
  input  logic [NUM_BANKS*NUM_WPORTS*ROW_BITS-1:0]    WrAddr,
  input  logic [NUM_BANKS*NUM_WPORTS*DATA_WIDTH-1:0]  WrData,
  input  logic [NUM_BANKS*NUM_RPORTS-1:0]             RdValid,
  input  logic [NUM_BANKS*NUM_RPORTS*ROW_BITS-1:0]    RdAddr,
  output logic [NUM_BANKS*NUM_RPORTS*DATA_WIDTH-1:0]  RdData,
  output logic [NUM_BANKS*NUM_RPORTS-1:0]             RdDataValid,
  output logic [15:0]                                 CollisionCount
);
  localparam int NW = NUM_WPORTS;
  localparam int NR = NUM_RPORTS;

  logic [NUM_BANKS-1:0][2:0] bankDrops;
  logic [16:0]               dropSum, nextCount;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
    banked_unified_buffer_bank #(
      .DW(DATA_WIDTH), .BD(BANK_DEPTH), .NW(NW), .NR(NR), .RL(READ_LATENCY), .RB(ROW_BITS)
    ) uBank (
      .clk        (CLK),
      .rstN       (ASYNC_RST),
      .syncRst    (SYNC_RST),
      .en         (EN),
      .wrValid    (WrValid[b*NW +: NW]),
      .wrAddr     (WrAddr[b*NW*ROW_BITS +: NW*ROW_BITS]),
      .wrData     (WrData[b*NW*DATA_WIDTH +: NW*DATA_WIDTH]),
      .rdValid    (RdValid[b*NR +: NR]),
      .rdAddr     (RdAddr[b*NR*ROW_BITS +: NR*ROW_BITS]),
      .rdData     (RdData[b*NR*DATA_WIDTH +: NR*DATA_WIDTH]),
      .rdDataValid(RdDataValid[b*NR +: NR]),
      .dropCnt    (bankDrops[b])
    );
  end

  always_comb begin
    dropSum = '0;
    for (int b = 0; b < NUM_BANKS; b++) dropSum = dropSum + 17'(bankDrops[b]);
    nextCount = {1'b0, CollisionCount} + dropSum;
  end

  always_ff @(posedge CLK or negedge ASYNC_RST)
    if (!ASYNC_RST)    CollisionCount <= '0;
    else if (SYNC_RST) CollisionCount <= '0;
    else if (EN)       CollisionCount <= nextCount[16] ? 16'hFFFF : nextCount[15:0];
endmodule
